array_loader: RTL and testbench

ARRAY_LOADER -- requirements
Module: array_loader

---
 rtl/array_loader.sv | 121 ++++++++++++
 tb/tb_array_loader.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/array_loader.sv
// Array loader: collects 16 bytes into the M_out image, pulses Start, waits for a fresh finder Done.
// Latency: Start one cycle after the 16th byte edge; Din_Ready one cycle after the qualifying Done edge.
// Backpressure: Din_Ready low outside FILL and while Flush is high; Din is only consumed in FILL.
module array_loader (
   input  logic         Clk,
   input  logic         Reset,
   input  logic [7:0]   Din,
   input  logic         Din_Valid,
   output logic         Din_Ready,
   input  logic         Flush,
   output logic [127:0] M_out,
   output logic         Start,
   input  logic         Done,
   output logic         Qf,
   output logic         Qs,
   output logic         Qw,
   output logic [3:0]   Byte_cnt,
   output logic [7:0]   Array_cnt
);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t         r_state;
   state_t         w_next_state;
   logic [127:0]   r_m;
   logic [3:0]     r_byte_cnt;
   logic [7:0]     r_array_cnt;
   logic           r_seen_low;
   logic           w_din_ready;
   logic           w_start;
   logic           w_xfer;
   logic           w_wait_exit;

   // A byte is accepted only in FILL with no flush pending.
   assign w_xfer      = (r_state == S_FILL) && Din_Valid && !Flush;
   // A Done that was already high before the finder ran must not end WAIT;
   // require a low sample first.
   assign w_wait_exit = (r_state == S_WAIT) && Done && r_seen_low;

   // State register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_FILL;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      w_next_state = r_state;
      w_din_ready  = 1'b0;
      w_start      = 1'b0;
      case (r_state)
         S_FILL: begin
            w_din_ready = !Flush;
            if (w_xfer && (r_byte_cnt == 4'd15)) begin
               w_next_state = S_START;
            end
         end
         S_START: begin
            w_start      = 1'b1;
            w_next_state = S_WAIT;
         end
         S_WAIT: begin
            if (w_wait_exit) begin
               w_next_state = S_FILL;
            end
         end
         default: begin
            w_next_state = S_FILL;
         end
      endcase
   end

   // Array image, write index, completed-array count and the Done-low tracker.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_m         <= '0;
         r_byte_cnt  <= 4'd0;
         r_array_cnt <= 8'd0;
         r_seen_low  <= 1'b0;
      end else begin
         case (r_state)
            S_FILL: begin
               if (Flush) begin
                  r_byte_cnt <= 4'd0;
               end else if (Din_Valid) begin
                  r_m[{r_byte_cnt, 3'b000} +: 8] <= Din;
                  // Natural 4-bit wrap leaves the index at 0 for the next array.
                  r_byte_cnt <= r_byte_cnt + 4'd1;
               end
            end
            S_WAIT: begin
               if (w_wait_exit) begin
                  r_seen_low  <= 1'b0;
                  r_array_cnt <= r_array_cnt + 8'd1;
               end else if (!Done) begin
                  r_seen_low <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign Din_Ready = w_din_ready;
   assign Start     = w_start;
   assign M_out     = r_m;
   assign Byte_cnt  = r_byte_cnt;
   assign Array_cnt = r_array_cnt;
   assign Qf        = (r_state == S_FILL);
   assign Qs        = (r_state == S_START);
   assign Qw        = (r_state == S_WAIT);

endmodule

// File: tb/tb_array_loader.sv
// Bench for array_loader: table-driven stream, hand-written corner sequences,
// and randomized traffic checked every cycle against a transaction-level model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_array_loader;

   logic         Clk;
   logic         Reset;
   logic [7:0]   Din;
   logic         Din_Valid;
   logic         Din_Ready;
   logic         Flush;
   logic [127:0] M_out;
   logic         Start;
   logic         Done;
   logic         Qf;
   logic         Qs;
   logic         Qw;
   logic [3:0]   Byte_cnt;
   logic [7:0]   Array_cnt;

   int total = 0;
   int bad   = 0;

   array_loader dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .Din       (Din),
      .Din_Valid (Din_Valid),
      .Din_Ready (Din_Ready),
      .Flush     (Flush),
      .M_out     (M_out),
      .Start     (Start),
      .Done      (Done),
      .Qf        (Qf),
      .Qs        (Qs),
      .Qw        (Qw),
      .Byte_cnt  (Byte_cnt),
      .Array_cnt (Array_cnt)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // ---------------- reference model ----------------
   // phase: 0 = filling, 1 = start pulse cycle, 2 = waiting for finder
   logic [7:0] m_ref [16];
   int         bcnt_ref;
   int         acnt_ref;
   int         phase_ref;
   bit         seen_ref;

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_ref[i] = 8'h00;
      bcnt_ref  = 0;
      acnt_ref  = 0;
      phase_ref = 0;
      seen_ref  = 1'b0;
   endtask

   task automatic model_step();
      if (phase_ref == 0) begin
         if (Flush) begin
            bcnt_ref = 0;
         end else if (Din_Valid) begin
            m_ref[bcnt_ref] = Din;
            bcnt_ref = (bcnt_ref + 1) % 16;
            if (bcnt_ref == 0) phase_ref = 1;
         end
      end else if (phase_ref == 1) begin
         phase_ref = 2;
      end else begin
         if (Done && seen_ref) begin
            phase_ref = 0;
            seen_ref  = 1'b0;
            acnt_ref  = (acnt_ref + 1) % 256;
         end else if (!Done) begin
            seen_ref = 1'b1;
         end
      end
   endtask

   function automatic logic [127:0] m_img();
      logic [127:0] v;
      v = '0;
      for (int i = 0; i < 16; i++) v[i*8 +: 8] = m_ref[i];
      return v;
   endfunction

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic check_all();
      chk("qf",        128'(Qf),        128'(phase_ref == 0));
      chk("qs",        128'(Qs),        128'(phase_ref == 1));
      chk("qw",        128'(Qw),        128'(phase_ref == 2));
      chk("start",     128'(Start),     128'(phase_ref == 1));
      chk("din_ready", 128'(Din_Ready), 128'((phase_ref == 0) && !Flush));
      chk("byte_cnt",  128'(Byte_cnt),  128'(bcnt_ref));
      chk("array_cnt", 128'(Array_cnt), 128'(acnt_ref));
      chk("m_out",     M_out,           m_img());
   endtask

   task automatic set_in(input logic [7:0] d, input logic v, input logic f, input logic dn);
      Din       = d;
      Din_Valid = v;
      Flush     = f;
      Done      = dn;
   endtask

   task automatic tick();
      model_step();
      @(posedge Clk);
      #1;
      check_all();
   endtask

   // ---------------- stimulus tables ----------------
   typedef struct {
      logic [7:0] din;
      logic [3:0] exp_bcnt;
      logic       exp_start;
   } vec_t;

   logic [7:0] stream [16];
   vec_t       vt [16];
   localparam logic [127:0] STREAM_IMG = 128'hF5_84_02_02_99_02_85_F4_F4_23_83_90_F4_64_9A_3B;
   localparam logic [127:0] RAMP_IMG   = 128'h0F0E0D0C0B0A09080706050403020100;

   initial begin
      stream = '{8'h3B, 8'h9A, 8'h64, 8'hF4, 8'h90, 8'h83, 8'h23, 8'hF4,
                 8'hF4, 8'h85, 8'h02, 8'h99, 8'h02, 8'h02, 8'h84, 8'hF5};
      for (int i = 0; i < 16; i++) begin
         vt[i].din       = stream[i];
         vt[i].exp_bcnt  = 4'((i + 1) % 16);
         vt[i].exp_start = (i == 15);
      end

      // ---- reset, with a stale Done already high ----
      Reset = 1'b0;
      set_in(8'h00, 1'b0, 1'b0, 1'b1);
      model_reset();
      #12;
      chk("rst_qf",    128'(Qf),        128'(1));
      chk("rst_qsqw",  128'({Qs, Qw}),  128'(0));
      chk("rst_start", 128'(Start),     128'(0));
      chk("rst_m",     M_out,           128'(0));
      chk("rst_cnts",  128'({Byte_cnt, Array_cnt}), 128'(0));
      #10;
      Reset = 1'b1;                     // released mid-cycle, away from the edge
      #1;
      chk("rst_rdy", 128'(Din_Ready), 128'(1));

      // ---- back-to-back stream from the table ----
      for (int i = 0; i < 16; i++) begin
         set_in(vt[i].din, 1'b1, 1'b0, 1'b1);
         tick();
         chk("tbl_bcnt",  128'(Byte_cnt), 128'(vt[i].exp_bcnt));
         chk("tbl_start", 128'(Start),    128'(vt[i].exp_start));
      end
      chk("stream_m", M_out, STREAM_IMG);
      chk("stream_qs", 128'(Qs), 128'(1));

      // ---- finder drops Done after Start, raises it 20 cycles later ----
      set_in(8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      chk("wait_entry_qw", 128'(Qw), 128'(1));
      Done = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("wait_hold", 128'(Qw), 128'(1));
      end
      Done = 1'b1;
      tick();
      chk("wait_exit_qf",   128'(Qf),        128'(1));
      chk("wait_exit_acnt", 128'(Array_cnt), 128'(1));
      chk("wait_exit_rdy",  128'(Din_Ready), 128'(1));
      chk("wait_exit_bcnt", 128'(Byte_cnt),  128'(0));

      // ---- stale Done held high through START and WAIT; Flush ignored in START ----
      for (int i = 0; i < 16; i++) begin
         set_in(8'(i * 7 + 1), 1'b1, 1'b0, 1'b1);
         tick();
      end
      set_in(8'h55, 1'b1, 1'b1, 1'b1);
      tick();
      chk("stale_qw0", 128'(Qw), 128'(1));
      Flush = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stale_done_wait", 128'(Qw), 128'(1));
      end
      Done = 1'b0;
      tick();
      chk("stale_low_wait", 128'(Qw), 128'(1));
      Done = 1'b1;
      tick();
      chk("stale_exit_qf",   128'(Qf),        128'(1));
      chk("stale_exit_acnt", 128'(Array_cnt), 128'(2));

      // ---- partial array, flush, then 16 fresh bytes ----
      for (int i = 0; i < 5; i++) begin
         set_in(8'hA0 + 8'(i), 1'b1, 1'b0, 1'b1);
         tick();
      end
      set_in(8'hEE, 1'b1, 1'b1, 1'b1);
      tick();
      chk("flush_bcnt", 128'(Byte_cnt), 128'(0));
      for (int i = 0; i < 16; i++) begin
         set_in(8'(i), 1'b1, 1'b0, 1'b1);
         tick();
         chk("flush_start", 128'(Start), 128'(i == 15));
      end
      chk("flush_m", M_out, RAMP_IMG);
      set_in(8'h00, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      Done = 1'b1;
      tick();
      chk("flush_exit_acnt", 128'(Array_cnt), 128'(3));

      // ---- random gaps give the same image; reset asserted in WAIT ----
      for (int i = 0; i < 16; i++) begin
         int ng;
         ng = $urandom_range(3, 0);
         for (int g = 0; g < ng; g++) begin
            set_in(8'($urandom), 1'b0, 1'b0, 1'b1);
            tick();
         end
         set_in(stream[i], 1'b1, 1'b0, 1'b1);
         tick();
      end
      chk("gap_m", M_out, STREAM_IMG);
      set_in(8'h00, 1'b0, 1'b0, 1'b1);
      tick();
      tick();
      chk("gap_in_wait", 128'(Qw), 128'(1));
      #2;
      Reset = 1'b0;
      #1;
      chk("rstw_qf",    128'(Qf),        128'(1));
      chk("rstw_m",     M_out,           128'(0));
      chk("rstw_acnt",  128'(Array_cnt), 128'(0));
      chk("rstw_start", 128'(Start),     128'(0));
      model_reset();
      @(negedge Clk);
      #2;
      Reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("no_start_after_rst", 128'(Start), 128'(0));
      end

      // ---- randomized arrays against the model; count wraps after 256 ----
      for (int a = 0; a < 256; a++) begin
         int guard;
         guard = 0;
         while (phase_ref == 0 && guard < 400) begin
            set_in(8'($urandom), ($urandom_range(3, 0) != 0), ($urandom_range(31, 0) == 0),
                   1'($urandom));
            tick();
            guard++;
         end
         chk("rand_fill_bound", 128'(phase_ref), 128'(1));
         set_in(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
         tick();
         for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
            set_in(8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
            tick();
         end
         set_in(8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
         tick();
         set_in(8'($urandom), 1'($urandom), 1'($urandom), 1'b1);
         tick();
         chk("rand_back_to_fill", 128'(Qf), 128'(1));
         if (a == 254) chk("acnt_255", 128'(Array_cnt), 128'(255));
      end
      chk("acnt_wrap", 128'(Array_cnt), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
